unidade_controle: RTL and testbench

// - Multi-cycle control FSM directly upstream of BancoDeRegistradores: captures an instruction word and,
//   per step, drives the register-file write enables (registers_in), read select (register_out) and bus mux.
// - Also drives Ain/Gin/addsub for the ALU path. One instruction in flight; done pulses on the last step.

---
 rtl/unidade_controle.sv | 161 ++++++++++++++++
 tb/tb_unidade_controle.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// unidade_controle
//   Multi-cycle control FSM sitting in front of the register file. It captures
//   a 9-bit instruction word from din when idle and run is high, then steps
//   through the register-file write enables, read select, bus mux and ALU
//   strobes needed to execute it. One instruction is in flight at a time.
//
//   Instruction word: IR[8:6]=op, IR[5:3]=Rx, IR[2:0]=Ry
//     000 mv  Rx <- Ry        (1 step)
//     001 mvi Rx <- din       (1 step)
//     010 add Rx <- Rx + Ry   (3 steps)
//     011 sub Rx <- Rx - Ry   (3 steps)
//     1xx reserved, executes as nop (1 step)
//   A register index outside R0..R(NUM_REGS-1) on a non-reserved op also
//   executes as a nop.
//
// Ports
//   clock         in   rising-edge clock
//   resetn        in   asynchronous active-low reset
//   run           in   start request, sampled only while idle
//   din           in   external data; din[8:0] is the instruction, full word is the mvi operand
//   registers_in  out  one-hot register-file write enables
//   register_out  out  register-file read select
//   bus_sel       out  bus mux: 00 register file, 01 din, 10 G
//   IRin          out  instruction capture strobe
//   Ain           out  load ALU operand register A
//   Gin           out  load ALU result register G
//   addsub        out  ALU op: 0 add, 1 sub
//   busy          out  high whenever an instruction is in flight
//   done          out  single-cycle pulse in the final step of an instruction

module unidade_controle #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 7
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [NUM_REGS-1:0]   registers_in,
  output logic [2:0]            register_out,
  output logic [1:0]            bus_sel,
  output logic                  IRin,
  output logic                  Ain,
  output logic                  Gin,
  output logic                  addsub,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  localparam logic [1:0] BUS_REGS = 2'b00;
  localparam logic [1:0] BUS_DIN  = 2'b01;
  localparam logic [1:0] BUS_G    = 2'b10;

  state_t     state;
  logic [8:0] ir;

  // Upper din bits only matter to the datapath (mvi operand), not to control.
  logic unused_din;
  assign unused_din = ^din[DATA_WIDTH-1:9];

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       reserved;
  logic       bad_reg;
  logic       is_alu;

  assign op       = ir[8:6];
  assign rx       = ir[5:3];
  assign ry       = ir[2:0];
  assign reserved = op[2];
  assign bad_reg  = (int'(rx) >= NUM_REGS) || (int'(ry) >= NUM_REGS);
  // Only a well-formed add/sub leaves T1 for the ALU steps.
  assign is_alu   = !reserved && !bad_reg && (op[2:1] == 2'b01);

  function automatic logic [NUM_REGS-1:0] onehot(input logic [2:0] idx);
    onehot = '0;
    if (int'(idx) < NUM_REGS)
      onehot = NUM_REGS'(1) << idx;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            ir    <= din[8:0];
            state <= S_T1;
          end
        end
        S_T1:    state <= is_alu ? S_T2 : S_IDLE;
        S_T2:    state <= S_T3;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    registers_in = '0;
    register_out = 3'd0;
    bus_sel      = BUS_REGS;
    IRin         = 1'b0;
    Ain          = 1'b0;
    Gin          = 1'b0;
    addsub       = 1'b0;
    busy         = (state != S_IDLE);
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        // Gated by resetn so the strobe stays low while reset is asserted.
        IRin = run && resetn;
      end
      S_T1: begin
        if (reserved || bad_reg) begin
          done = 1'b1;
        end else begin
          case (op[1:0])
            2'b00: begin
              register_out = ry;
              bus_sel      = BUS_REGS;
              registers_in = onehot(rx);
              done         = 1'b1;
            end
            2'b01: begin
              bus_sel      = BUS_DIN;
              registers_in = onehot(rx);
              done         = 1'b1;
            end
            default: begin
              register_out = rx;
              bus_sel      = BUS_REGS;
              Ain          = 1'b1;
            end
          endcase
        end
      end
      S_T2: begin
        register_out = ry;
        bus_sel      = BUS_REGS;
        Gin          = 1'b1;
        addsub       = ir[6];
      end
      default: begin
        bus_sel      = BUS_G;
        registers_in = onehot(rx);
        done         = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed testbench for unidade_controle. Inputs change 2 ns after each
// rising edge; outputs are sampled at that point as a packed vector:
//   {registers_in[6:0], register_out[2:0], bus_sel[1:0], IRin, Ain, Gin, addsub, busy, done}

module tb_unidade_controle;

  logic        clock = 1'b0;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic [6:0]  registers_in;
  logic [2:0]  register_out;
  logic [1:0]  bus_sel;
  logic        IRin, Ain, Gin, addsub, busy, done;

  int nvec = 0;
  int nerr = 0;

  unidade_controle #(.DATA_WIDTH(16), .NUM_REGS(7)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .run          (run),
    .din          (din),
    .registers_in (registers_in),
    .register_out (register_out),
    .bus_sel      (bus_sel),
    .IRin         (IRin),
    .Ain          (Ain),
    .Gin          (Gin),
    .addsub       (addsub),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  logic [17:0] obs;
  assign obs = {registers_in, register_out, bus_sel, IRin, Ain, Gin, addsub, busy, done};

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    logic [17:0] exp;
    resetn = 1'b0;
    run    = 1'b1;
    din    = 16'h002A;
    #12;
    exp = 18'd0;
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL reset_idle: got %h expected %h", obs, exp);
    end
    run = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL reset_release: got %h expected %h", obs, exp);
    end
  endtask

  // mvi R3: op=001 Rx=011 Ry=000 -> 9'b001_011_000 = 0x058
  task automatic test_mvi();
    logic [17:0] exp;
    din = 16'h0058;
    run = 1'b1;
    #1;
    exp = {7'b0, 3'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL mvi_irin: got %h expected %h", obs, exp);
    end
    step();
    run = 1'b0;
    din = 16'hBEEF;
    #1;
    exp = {7'b0001000, 3'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL mvi_t1: got %h expected %h", obs, exp);
    end
    step();
    nvec++;
    if (obs !== 18'd0) begin
      nerr++;
      $display("FAIL mvi_idle: got %h expected %h", obs, 18'd0);
    end
  endtask

  // mv R5 <- R2: 0x02A
  task automatic test_mv();
    logic [17:0] exp;
    din = 16'h002A;
    run = 1'b1;
    step();
    run = 1'b0;
    exp = {7'b0100000, 3'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL mv_t1: got %h expected %h", obs, exp);
    end
    step();
    nvec++;
    if (obs !== 18'd0) begin
      nerr++;
      $display("FAIL mv_idle: got %h expected %h", obs, 18'd0);
    end
  endtask

  // sub R1 <- R1 - R4: 0x0CC
  task automatic test_sub();
    logic [17:0] exp;
    din = 16'h00CC;
    run = 1'b1;
    step();
    run = 1'b0;
    exp = {7'b0, 3'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL sub_t1: got %h expected %h", obs, exp);
    end
    step();
    exp = {7'b0, 3'd4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL sub_t2: got %h expected %h", obs, exp);
    end
    step();
    exp = {7'b0000010, 3'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL sub_t3: got %h expected %h", obs, exp);
    end
    step();
    nvec++;
    if (obs !== 18'd0) begin
      nerr++;
      $display("FAIL sub_idle: got %h expected %h", obs, 18'd0);
    end
  endtask

  // add with Ry=7 (0x087), reserved op (0x100), mvi with Rx=7 (0x078)
  task automatic test_invalid();
    logic [15:0] words [3] = '{16'h0087, 16'h0100, 16'h0078};
    logic [17:0] exp;
    exp = {7'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      din = words[i];
      run = 1'b1;
      step();
      run = 1'b0;
      nvec++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL invalid_t1[%h]: got %h expected %h", words[i], obs, exp);
      end
      step();
      nvec++;
      if (obs !== 18'd0) begin
        nerr++;
        $display("FAIL invalid_idle[%h]: got %h expected %h", words[i], obs, 18'd0);
      end
    end
  endtask

  // add R2 <- R2 + R6 (0x096) with run held high; din switches to mv R5<-R2
  // while busy, which must only be captured in the idle cycle after done.
  task automatic test_back_to_back();
    logic [17:0] exp;
    din = 16'h0096;
    run = 1'b1;
    step();
    din = 16'h002A;
    exp = {7'b0, 3'd2, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL b2b_add_t1: got %h expected %h", obs, exp);
    end
    step();
    exp = {7'b0, 3'd6, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL b2b_add_t2: got %h expected %h", obs, exp);
    end
    step();
    exp = {7'b0000100, 3'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL b2b_add_t3: got %h expected %h", obs, exp);
    end
    step();
    exp = {7'b0, 3'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL b2b_idle_capture: got %h expected %h", obs, exp);
    end
    step();
    run = 1'b0;
    exp = {7'b0100000, 3'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL b2b_mv_t1: got %h expected %h", obs, exp);
    end
    step();
    nvec++;
    if (obs !== 18'd0) begin
      nerr++;
      $display("FAIL b2b_idle: got %h expected %h", obs, 18'd0);
    end
  endtask

  // Asynchronous reset in T2 of an add, then a normal mv afterwards.
  task automatic test_reset_mid();
    logic [17:0] exp;
    din = 16'h0096;
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    exp = {7'b0, 3'd6, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL rstmid_t2: got %h expected %h", obs, exp);
    end
    #1;
    resetn = 1'b0;
    #1;
    nvec++;
    if (obs !== 18'd0) begin
      nerr++;
      $display("FAIL rstmid_async: got %h expected %h", obs, 18'd0);
    end
    step();
    resetn = 1'b1;
    step();
    nvec++;
    if (obs !== 18'd0) begin
      nerr++;
      $display("FAIL rstmid_after: got %h expected %h", obs, 18'd0);
    end
    din = 16'h002A;
    run = 1'b1;
    step();
    run = 1'b0;
    exp = {7'b0100000, 3'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL rstmid_mv_t1: got %h expected %h", obs, exp);
    end
    step();
    nvec++;
    if (obs !== 18'd0) begin
      nerr++;
      $display("FAIL rstmid_mv_idle: got %h expected %h", obs, 18'd0);
    end
  endtask

  initial begin
    test_reset();
    test_mvi();
    test_mv();
    test_sub();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
